// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU into HI/LO, one operand bit per cycle.
// Optional: define MULDIV_EARLY_OUT_EN to end multiplies once the multiplier is exhausted.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] port_a,
    input  logic [WIDTH-1:0] port_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned W2 = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_a_raw;
    logic [WIDTH-1:0] r_b;
    logic [W2-1:0]    r_acc;
    logic [W2-1:0]    r_mcand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_div_zero;

    logic             w_accept;
    logic             w_run_last;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [W2-1:0]    w_mul_acc;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_rem_sub;
    logic             w_rem_ge;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic [W2-1:0]    w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign busy     = r_busy;
    assign done     = r_done;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_zero = r_div_zero;

    // Flush always wins over a coincident start.
    assign w_accept = start && !flush && (r_state == S_IDLE || r_state == S_DONE);

    // Operand magnitudes; op[0] selects the signed variants.
    assign w_a_neg = op[0] && port_a[WIDTH-1];
    assign w_b_neg = op[0] && port_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~port_a + WIDTH'(1)) : port_a;
    assign w_b_mag = w_b_neg ? (~port_b + WIDTH'(1)) : port_b;

    // Shift-add multiply step and restoring divide step ({rem, quo} share r_acc).
    assign w_mul_acc = r_acc + (r_b[0] ? r_mcand : '0);
    assign w_rem_sh  = r_acc[W2-1:WIDTH-1];
    assign w_rem_ge  = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_b;

    assign w_quo      = r_acc[WIDTH-1:0];
    assign w_rem      = r_acc[W2-1:WIDTH];
    assign w_prod_fix = r_neg_q ? (~r_acc + W2'(1)) : r_acc;
    assign w_quo_fix  = r_neg_q ? (~w_quo + WIDTH'(1)) : w_quo;
    assign w_rem_fix  = r_neg_r ? (~w_rem + WIDTH'(1)) : w_rem;

`ifdef MULDIV_EARLY_OUT_EN
    assign w_run_last = (r_cnt == CW'(WIDTH - 1)) || (!r_is_div && (r_b[WIDTH-1:1] == '0));
`else
    assign w_run_last = (r_cnt == CW'(WIDTH - 1));
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN: begin
                if (flush)           w_state_nxt = S_IDLE;
                else if (w_run_last) w_state_nxt = S_FIX;
            end
            S_FIX:   w_state_nxt = flush ? S_IDLE : S_DONE;
            S_DONE:  w_state_nxt = w_accept ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_FIX);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_a_raw    <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= '0;
            r_is_div   <= op[1];
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_a_raw    <= port_a;
            r_b        <= w_b_mag;
            r_acc      <= op[1] ? W2'(w_a_mag) : '0;
            r_mcand    <= W2'(w_a_mag);
            r_div_zero <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_is_div) begin
                r_acc <= {(w_rem_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_rem_ge};
            end else begin
                r_acc   <= w_mul_acc;
                r_mcand <= r_mcand << 1;
                r_b     <= r_b >> 1;
            end
        end else if (r_state == S_FIX && !flush) begin
            // Divisor zero reports the raw dividend rather than the negated remainder.
            if (r_is_div && r_b == '0) begin
                r_hi       <= r_a_raw;
                r_lo       <= '1;
                r_div_zero <= 1'b1;
            end else if (r_is_div) begin
                r_hi <= w_rem_fix;
                r_lo <= w_quo_fix;
            end else begin
                r_hi <= w_prod_fix[W2-1:WIDTH];
                r_lo <= w_prod_fix[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: a 32-bit and an 8-bit instance.
module tb_muldiv_unit;
    logic        CLK = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] port_a;
    logic [31:0] port_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    logic        rst8_n;
    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        flush8;
    logic        busy8;
    logic        done8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;
    logic        div_zero8;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    always #5 CLK = ~CLK;

    muldiv_unit #(.WIDTH(32)) dut (
        .CLK(CLK), .nRST(rst_n), .start(start), .op(op), .port_a(port_a), .port_b(port_b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .CLK(CLK), .nRST(rst8_n), .start(start8), .op(op8), .port_a(a8), .port_b(b8),
        .flush(flush8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(div_zero8)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Present a request for one cycle; returns at the negedge of cycle 1.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        op     = o;
        port_a = a;
        port_b = b;
        @(negedge CLK);
        start  = 1'b0;
    endtask

    // From cycle k0, wait for done; returns in the done cycle (or -1 on timeout).
    task automatic wait_done(input int k0, output int done_cyc, output int busy_cyc);
        int k = k0;
        busy_cyc = 0;
        while (!done && k < 100) begin
            if (busy) busy_cyc++;
            @(negedge CLK);
            k++;
        end
        done_cyc = done ? k : -1;
    endtask

    task automatic op32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int done_cyc, output int busy_cyc);
        @(negedge CLK);
        issue(o, a, b);
        wait_done(1, done_cyc, busy_cyc);
    endtask

    task automatic op8w(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        output int done_cyc);
        int k = 1;
        @(negedge CLK);
        start8 = 1'b1;
        op8    = o;
        a8     = a;
        b8     = b;
        @(negedge CLK);
        start8 = 1'b0;
        while (!done8 && k < 50) begin
            @(negedge CLK);
            k++;
        end
        done_cyc = done8 ? k : -1;
    endtask

    initial begin
        int dc;
        int bc;
        int n_done;
        rst_n  = 1'b0;
        rst8_n = 1'b0;
        start  = 1'b0; op = 2'b00; port_a = '0; port_b = '0; flush = 1'b0;
        start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0; flush8 = 1'b0;
        repeat (3) @(negedge CLK);
        rst_n  = 1'b1;
        rst8_n = 1'b1;
        @(negedge CLK);

        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_dz", 64'(div_zero), 64'd0);

        op32(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, bc);
        check("multu_done_cyc", 64'(dc), 64'd34);
        check("multu_busy_cyc", 64'(bc), 64'd33);
        check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        check("multu_lo", 64'(lo), 64'h0000_0001);
        check("multu_dz", 64'(div_zero), 64'd0);
        @(negedge CLK);
        check("multu_done_pulse", 64'(done), 64'd0);
        check("multu_busy_after", 64'(busy), 64'd0);

        op32(OP_MULT, 32'hFFFF_FFFD, 32'd7, dc, bc);
        check("mult_done_cyc", 64'(dc), 64'd34);
        check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo), 64'hFFFF_FFEB);
        issue(OP_DIVU, 32'd100, 32'd7);
        check("start_in_done_busy", 64'(busy), 64'd1);
        wait_done(1, dc, bc);
        check("divu_done_cyc", 64'(dc), 64'd34);
        check("divu_lo", 64'(lo), 64'd14);
        check("divu_hi", 64'(hi), 64'd2);

        op32(OP_DIV, 32'hFFFF_FFF9, 32'd2, dc, bc);
        check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
        op32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, dc, bc);
        check("div_ovf_lo", 64'(lo), 64'h8000_0000);
        check("div_ovf_hi", 64'(hi), 64'd0);
        check("div_ovf_dz", 64'(div_zero), 64'd0);

        op32(OP_DIVU, 32'd5, 32'd0, dc, bc);
        check("dz_done_cyc", 64'(dc), 64'd34);
        check("dz_lo", 64'(lo), 64'hFFFF_FFFF);
        check("dz_hi", 64'(hi), 64'd5);
        check("dz_flag", 64'(div_zero), 64'd1);
        @(negedge CLK);
        check("dz_held", 64'(div_zero), 64'd1);
        issue(OP_DIVU, 32'd100, 32'd7);
        check("dz_cleared", 64'(div_zero), 64'd0);
        wait_done(1, dc, bc);
        check("prior_lo", 64'(lo), 64'd14);
        check("prior_hi", 64'(hi), 64'd2);

        // Flush in RUN cycle 10: no done, prior result kept.
        @(negedge CLK);
        issue(OP_MULTU, 32'd3, 32'd5);
        repeat (9) @(negedge CLK);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        n_done = 0;
        repeat (40) begin
            if (done) n_done++;
            @(negedge CLK);
        end
        check("flush_no_done", 64'(n_done), 64'd0);
        check("flush_hi", 64'(hi), 64'd2);
        check("flush_lo", 64'(lo), 64'd14);

        // start + flush in IDLE is dropped.
        start = 1'b1; op = OP_MULTU; port_a = 32'd9; port_b = 32'd9; flush = 1'b1;
        @(negedge CLK);
        start = 1'b0; flush = 1'b0;
        check("sf_idle_busy", 64'(busy), 64'd0);
        @(negedge CLK);
        check("sf_idle_busy2", 64'(busy), 64'd0);
        check("sf_idle_lo", 64'(lo), 64'd14);

        // start while busy is ignored.
        issue(OP_MULTU, 32'd6, 32'd7);
        repeat (4) @(negedge CLK);
        issue(OP_DIVU, 32'd1000, 32'd3);
        wait_done(6, dc, bc);
        check("busy_start_cyc", 64'(dc), 64'd34);
        check("busy_start_hi", 64'(hi), 64'd0);
        check("busy_start_lo", 64'(lo), 64'd42);

        // 8-bit instance.
        op8w(OP_MULTU, 8'hFF, 8'hFF, dc);
        check("w8_done_cyc", 64'(dc), 64'd10);
        check("w8_hi", 64'(hi8), 64'hFE);
        check("w8_lo", 64'(lo8), 64'h01);
        op8w(OP_DIVU, 8'd9, 8'd0, dc);
        check("w8_dz_hi", 64'(hi8), 64'd9);
        check("w8_dz_lo", 64'(lo8), 64'hFF);
        check("w8_dz_flag", 64'(div_zero8), 64'd1);
        @(negedge CLK);
        start8 = 1'b1; op8 = OP_MULTU; a8 = 8'hFF; b8 = 8'hFF;
        @(negedge CLK);
        start8 = 1'b0;
        repeat (3) @(negedge CLK);
        rst8_n = 1'b0;
        #1;
        check("w8_rst_busy", 64'(busy8), 64'd0);
        check("w8_rst_done", 64'(done8), 64'd0);
        check("w8_rst_hi", 64'(hi8), 64'd0);
        check("w8_rst_lo", 64'(lo8), 64'd0);
        check("w8_rst_dz", 64'(div_zero8), 64'd0);
        @(negedge CLK);
        rst8_n = 1'b1;
        @(negedge CLK);
        check("w8_idle_busy", 64'(busy8), 64'd0);
        repeat (12) @(negedge CLK);
        check("w8_idle_done", 64'(done8), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
